// File: rtl/letc_core_stage_fetch2_buf.sv
// -----------------------------------------------------------------------------
// letc_core_stage_fetch2_buf
//
// Second fetch stage instruction buffer. Every request issued by F1 reserves a
// slot in a circular queue (tail = alloc pointer). IMSS responses arrive in
// request order and fill slots in order (fill pointer). Decode consumes filled
// slots from the head. A flush empties the queue at once; responses still owed
// by the IMSS for flushed requests are swallowed by a drop counter.
//
// Ports
//   clk, rst_n        clock, asynchronous active-low reset
//   f1_to_f2_valid    F1 issued an IMSS request for f1_to_f2_pc
//   f1_to_f2_pc       PC of that request
//   f2_ready          a request can be accepted this cycle
//   f2_flush          discard all queued and in-flight fetches
//   f2_stall          decode cannot take an instruction this cycle
//   imss_rsp_valid    one IMSS response this cycle (in request order)
//   imss_rsp_data     response data (32 or 64 bits)
//   f2_to_d_valid     instruction presented to decode
//   f2_to_d_pc        PC of the presented instruction
//   f2_to_d_instr     presented instruction
//   f2_occupancy      allocated entries, filled or not
// -----------------------------------------------------------------------------
module letc_core_stage_fetch2_buf #(
  parameter int DEPTH   = 4,
  parameter int FETCH_W = 32,
  parameter int PC_W    = 32
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       f1_to_f2_valid,
  input  logic [PC_W-1:0]            f1_to_f2_pc,
  output logic                       f2_ready,
  input  logic                       f2_flush,
  input  logic                       f2_stall,
  input  logic                       imss_rsp_valid,
  input  logic [FETCH_W-1:0]         imss_rsp_data,
  output logic                       f2_to_d_valid,
  output logic [PC_W-1:0]            f2_to_d_pc,
  output logic [31:0]                f2_to_d_instr,
  output logic [$clog2(DEPTH+1)-1:0] f2_occupancy
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int OCC_W = $clog2(DEPTH+1);

  logic [PTR_W-1:0] alloc_q, alloc_d;
  logic [PTR_W-1:0] fill_q,  fill_d;
  logic [PTR_W-1:0] head_q,  head_d;
  logic [OCC_W-1:0] occ_q,   occ_d;
  // Allocated-but-unfilled entries; saves walking the filled bits on flush.
  logic [OCC_W-1:0] unf_q,   unf_d;
  logic [OCC_W-1:0] drop_q,  drop_d;
  logic [DEPTH-1:0] filled_q, filled_d;

  logic [PC_W-1:0]  pc_mem_q    [DEPTH];
  logic [PC_W-1:0]  pc_mem_d    [DEPTH];
  logic [31:0]      instr_mem_q [DEPTH];
  logic [31:0]      instr_mem_d [DEPTH];

  logic [31:0]      rsp_instr;
  logic [OCC_W:0]   ready_sum;
  logic [OCC_W:0]   flush_sum;
  logic [OCC_W:0]   flush_drop;
  logic             do_alloc;
  logic             do_pop;
  logic             rsp_drop;
  logic             rsp_fill;

  // A 64-bit fetch returns an aligned doubleword; the word is picked by the
  // PC of the entry being filled.
  generate
    if (FETCH_W == 64) begin : g_sel64
      assign rsp_instr = pc_mem_q[fill_q][2] ? imss_rsp_data[FETCH_W-1:32]
                                            : imss_rsp_data[31:0];
    end else begin : g_sel32
      assign rsp_instr = imss_rsp_data[31:0];
    end
  endgenerate

  // Responses still owed for flushed requests reserve queue space so the
  // IMSS can never have more outstanding responses than DEPTH.
  assign ready_sum     = {1'b0, occ_q} + {1'b0, drop_q};
  assign f2_ready      = ready_sum < (OCC_W+1)'(DEPTH);

  assign f2_to_d_valid = (occ_q != '0) & filled_q[head_q] & ~f2_flush;
  assign f2_to_d_pc    = pc_mem_q[head_q];
  assign f2_to_d_instr = instr_mem_q[head_q];
  assign f2_occupancy  = occ_q;

  assign do_alloc = f1_to_f2_valid & f2_ready & ~f2_flush;
  assign do_pop   = f2_to_d_valid & ~f2_stall;
  assign rsp_drop = imss_rsp_valid & (drop_q != '0);
  assign rsp_fill = imss_rsp_valid & (drop_q == '0) & (unf_q != '0);

  // A response arriving in the flush cycle pays off one of the debts being
  // created (or an older one), hence the minus one; never below zero.
  assign flush_sum  = {1'b0, drop_q} + {1'b0, unf_q};
  assign flush_drop = (imss_rsp_valid && flush_sum != '0) ? flush_sum - 1'b1
                                                          : flush_sum;

  always_comb begin
    alloc_d     = alloc_q;
    fill_d      = fill_q;
    head_d      = head_q;
    occ_d       = occ_q;
    unf_d       = unf_q;
    drop_d      = drop_q;
    filled_d    = filled_q;
    pc_mem_d    = pc_mem_q;
    instr_mem_d = instr_mem_q;
    if (f2_flush) begin
      alloc_d = head_q;
      fill_d  = head_q;
      occ_d   = '0;
      unf_d   = '0;
      drop_d  = flush_drop[OCC_W-1:0];
    end else begin
      if (do_alloc) begin
        pc_mem_d[alloc_q] = f1_to_f2_pc;
        filled_d[alloc_q] = 1'b0;
        alloc_d           = alloc_q + 1'b1;
      end
      if (rsp_drop) begin
        drop_d = drop_q - 1'b1;
      end
      if (rsp_fill) begin
        instr_mem_d[fill_q] = rsp_instr;
        filled_d[fill_q]    = 1'b1;
        fill_d              = fill_q + 1'b1;
      end
      if (do_pop) begin
        head_d = head_q + 1'b1;
      end
      occ_d = occ_q + OCC_W'(do_alloc) - OCC_W'(do_pop);
      unf_d = unf_q + OCC_W'(do_alloc) - OCC_W'(rsp_fill);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alloc_q  <= '0;
      fill_q   <= '0;
      head_q   <= '0;
      occ_q    <= '0;
      unf_q    <= '0;
      drop_q   <= '0;
      filled_q <= '0;
    end else begin
      alloc_q  <= alloc_d;
      fill_q   <= fill_d;
      head_q   <= head_d;
      occ_q    <= occ_d;
      unf_q    <= unf_d;
      drop_q   <= drop_d;
      filled_q <= filled_d;
    end
  end

  // Payload storage carries no reset; the filled bits and pointers gate it.
  always_ff @(posedge clk) begin
    pc_mem_q    <= pc_mem_d;
    instr_mem_q <= instr_mem_d;
  end

`ifdef SIMULATION
  always @(posedge clk) begin
    if (rst_n) begin
      assert (!(imss_rsp_valid && drop_q == '0 && unf_q == '0))
        else $error("imss response with no outstanding request");
    end
  end
`endif

endmodule

// File: tb/tb_letc_core_stage_fetch2_buf.sv
module tb_letc_core_stage_fetch2_buf;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        f1_v;
  logic [31:0] f1_pc;
  logic        fl;
  logic        st;
  logic        rv;
  logic [63:0] rd64;
  logic [31:0] rd32;
  assign rd32 = rd64[31:0];

  logic        rdy64, v64, rdy32, v32;
  logic [31:0] pc64, in64, pc32, in32;
  logic [2:0]  occ64, occ32;

  letc_core_stage_fetch2_buf #(.DEPTH(DEPTH), .FETCH_W(64), .PC_W(32)) u64 (
    .clk(clk), .rst_n(rst_n),
    .f1_to_f2_valid(f1_v), .f1_to_f2_pc(f1_pc), .f2_ready(rdy64),
    .f2_flush(fl), .f2_stall(st),
    .imss_rsp_valid(rv), .imss_rsp_data(rd64),
    .f2_to_d_valid(v64), .f2_to_d_pc(pc64), .f2_to_d_instr(in64),
    .f2_occupancy(occ64)
  );

  letc_core_stage_fetch2_buf #(.DEPTH(DEPTH), .FETCH_W(32), .PC_W(32)) u32 (
    .clk(clk), .rst_n(rst_n),
    .f1_to_f2_valid(f1_v), .f1_to_f2_pc(f1_pc), .f2_ready(rdy32),
    .f2_flush(fl), .f2_stall(st),
    .imss_rsp_valid(rv), .imss_rsp_data(rd32),
    .f2_to_d_valid(v32), .f2_to_d_pc(pc32), .f2_to_d_instr(in32),
    .f2_occupancy(occ32)
  );

  // Reference model: in-order list of outstanding fetches plus a count of
  // responses still owed for flushed requests.
  typedef struct {
    logic [31:0] pc;
    bit          filled;
    logic [63:0] data;
  } ent_t;

  ent_t mq[$];
  int   mdrop;
  int   checks;
  int   errors;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic bit m_ready();
    return (mq.size() + mdrop) < DEPTH;
  endfunction

  function automatic bit m_valid();
    return (mq.size() > 0) && mq[0].filled && !fl;
  endfunction

  function automatic bit m_pending();
    if (mdrop > 0) return 1'b1;
    foreach (mq[i]) if (!mq[i].filled) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [31:0] sel64(input ent_t e);
    return e.pc[2] ? e.data[63:32] : e.data[31:0];
  endfunction

  task automatic m_check();
    bit ev;
    ev = m_valid();
    chk("valid64", v64, ev);
    chk("valid32", v32, ev);
    chk("ready64", rdy64, m_ready());
    chk("ready32", rdy32, m_ready());
    chk("occ64", occ64, mq.size());
    chk("occ32", occ32, mq.size());
    if (ev) begin
      chk("pc64", pc64, mq[0].pc);
      chk("pc32", pc32, mq[0].pc);
      chk("instr64", in64, sel64(mq[0]));
      chk("instr32", in32, mq[0].data[31:0]);
    end
  endtask

  task automatic m_update();
    bit   ev;
    bit   rdy;
    int   unf;
    ent_t e;
    ev  = m_valid();
    rdy = m_ready();
    if (fl) begin
      unf = 0;
      foreach (mq[i]) if (!mq[i].filled) unf++;
      mdrop = mdrop + unf - (rv ? 1 : 0);
      mq.delete();
    end else begin
      if (rv) begin
        if (mdrop > 0) mdrop--;
        else begin
          for (int i = 0; i < mq.size(); i++) begin
            if (!mq[i].filled) begin
              mq[i].filled = 1'b1;
              mq[i].data   = rd64;
              break;
            end
          end
        end
      end
      if (ev && !st) void'(mq.pop_front());
      if (f1_v && rdy) begin
        e.pc = f1_pc; e.filled = 1'b0; e.data = '0;
        mq.push_back(e);
      end
    end
  endtask

  task automatic drive(input bit v, input logic [31:0] pc, input bit f,
                       input bit s, input bit r, input logic [63:0] d);
    @(negedge clk);
    f1_v = v; f1_pc = pc; fl = f; st = s; rv = r; rd64 = d;
    #1;
    m_check();
  endtask

  task automatic tick();
    @(posedge clk);
    m_update();
  endtask

  task automatic cyc(input bit v, input logic [31:0] pc, input bit f,
                     input bit s, input bit r, input logic [63:0] d);
    drive(v, pc, f, s, r, d);
    tick();
  endtask

  initial begin
    logic [31:0] got[$];
    int          acc;
    int          rsp_n;
    bit          v;
    bit          r;
    checks = 0; errors = 0; mdrop = 0;
    rst_n = 1'b0; f1_v = 0; f1_pc = '0; fl = 0; st = 0; rv = 0; rd64 = '0;

    // reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_valid64", v64, 1'b0);   chk("rst_valid32", v32, 1'b0);
    chk("rst_occ64", occ64, 3'd0);   chk("rst_occ32", occ32, 3'd0);
    chk("rst_ready64", rdy64, 1'b1); chk("rst_ready32", rdy32, 1'b1);
    @(negedge clk) rst_n = 1'b1;

    // single fetch
    cyc(1, 32'h100, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 1, 64'h0000_0000_0000_0013);
    chk("sf_nobypass", v64, 1'b0);
    tick();
    drive(0, 0, 0, 0, 0, 0);
    chk("sf_valid", v64, 1'b1); chk("sf_pc", pc64, 32'h100);
    chk("sf_instr", in64, 32'h13); chk("sf_occ1", occ64, 3'd1);
    tick();
    drive(0, 0, 0, 0, 0, 0);
    chk("sf_occ0", occ64, 3'd0);
    tick();

    // full queue under stall, then drain in order
    for (int i = 0; i < 5; i++)
      cyc(i < 4, 32'h300 + 4 * i, 0, 1, i > 0,
          {32'h5000 + i - 1, 32'h6000 + i - 1});
    drive(0, 0, 0, 1, 0, 0);
    chk("full_ready", rdy64, 1'b0); chk("full_occ", occ64, 3'd4);
    chk("full_valid", v64, 1'b1);
    tick();
    for (int k = 0; k < 4; k++) begin
      drive(0, 0, 0, 0, 0, 0);
      chk("drain_pc", pc64, 32'h300 + 4 * k);
      chk("drain_instr64", in64, (k % 2) ? 32'h5000 + k : 32'h6000 + k);
      tick();
    end

    // flush with two responses still in flight
    cyc(1, 32'h400, 0, 0, 0, 0);
    cyc(1, 32'h404, 0, 0, 0, 0);
    cyc(1, 32'h408, 0, 0, 1, 64'h1111_1111_2222_2222);
    drive(0, 0, 1, 0, 0, 0);
    chk("fl_valid", v64, 1'b0);
    tick();
    drive(1, 32'h200, 0, 0, 0, 0);
    chk("fl_occ", occ64, 3'd0);
    tick();
    drive(0, 0, 0, 0, 1, 64'hDEAD_DEAD_DEAD_DEAD);
    chk("fl_drop1", v64, 1'b0);
    tick();
    drive(0, 0, 0, 0, 1, 64'hBEEF_BEEF_BEEF_BEEF);
    chk("fl_drop2", v64, 1'b0);
    tick();
    cyc(0, 0, 0, 0, 1, 64'h0000_0000_1234_5678);
    drive(0, 0, 0, 0, 0, 0);
    chk("fl_new_valid", v64, 1'b1); chk("fl_new_pc", pc64, 32'h200);
    chk("fl_new_instr", in64, 32'h1234_5678);
    tick();

    // flush and response in the same cycle
    cyc(1, 32'h500, 0, 0, 0, 0);
    cyc(1, 32'h504, 0, 0, 0, 0);
    drive(0, 0, 1, 0, 1, 64'h9999_9999_9999_9999);
    chk("flrsp_valid", v64, 1'b0);
    tick();
    cyc(1, 32'h508, 0, 0, 0, 0);
    cyc(1, 32'h50C, 0, 0, 0, 0);
    cyc(1, 32'h510, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 1, 64'h7777_7777_7777_7777);
    chk("flrsp_ready", rdy64, 1'b0);
    tick();
    for (int k = 0; k < 3; k++) cyc(0, 0, 0, 0, 1, {32'hE000 + k, 32'hF000 + k});
    repeat (3) cyc(0, 0, 0, 0, 0, 0);

    // 64-bit word select
    cyc(1, 32'h104, 0, 0, 0, 0);
    cyc(1, 32'h100, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 1, 64'hAAAA_AAAA_BBBB_BBBB);
    drive(0, 0, 0, 0, 1, 64'hAAAA_AAAA_BBBB_BBBB);
    chk("sel_hi64", in64, 32'hAAAA_AAAA); chk("sel_hi32", in32, 32'hBBBB_BBBB);
    tick();
    drive(0, 0, 0, 0, 0, 0);
    chk("sel_lo64", in64, 32'hBBBB_BBBB);
    tick();

    // pointer wrap: 10 back-to-back fetches
    acc = 0; rsp_n = 0;
    for (int c = 0; c < 30 && got.size() < 10; c++) begin
      v = acc < 10;
      r = m_pending();
      drive(v, 32'h600 + 4 * acc, 0, 0, r, {32'hB000 + rsp_n, 32'hC000 + rsp_n});
      if (v64) got.push_back(pc64);
      if (v && m_ready()) acc++;
      if (r) rsp_n++;
      tick();
    end
    chk("wrap_count", got.size(), 10);
    for (int i = 0; i < got.size(); i++) chk("wrap_pc", got[i], 32'h600 + 4 * i);

    // randomized traffic
    for (int c = 0; c < 400; c++) begin
      cyc($urandom_range(0, 1), $urandom & 32'hFFFF_FFFC,
          $urandom_range(0, 15) == 0, $urandom_range(0, 3) == 0,
          m_pending() && ($urandom_range(0, 1) == 1), {$urandom, $urandom});
    end

    // reset in the middle of operation
    cyc(1, 32'h700, 0, 0, 0, 0);
    cyc(1, 32'h704, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 1, 64'h0);
    @(negedge clk);
    #1;
    rst_n = 1'b0; f1_v = 0; fl = 0; st = 0; rv = 0;
    #1;
    chk("mrst_valid64", v64, 1'b0); chk("mrst_occ64", occ64, 3'd0);
    chk("mrst_ready64", rdy64, 1'b1); chk("mrst_valid32", v32, 1'b0);
    chk("mrst_occ32", occ32, 3'd0);
    mq.delete(); mdrop = 0;
    @(negedge clk) rst_n = 1'b1;
    cyc(1, 32'h800, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 1, 64'h0000_0000_0000_0073);
    drive(0, 0, 0, 0, 0, 0);
    chk("post_rst_pc", pc64, 32'h800); chk("post_rst_instr", in64, 32'h73);
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/letc_core_stage_fetch2_buf.md
LETC_CORE_STAGE_FETCH2_BUF -- requirements
Module: letc_core_stage_fetch2_buf

Interface
REQ-001 SHALL have parameter DEPTH, default 4, meaning instruction-queue entries; legal values are powers of two >= 2.
REQ-002 SHALL have parameter FETCH_W, default 32, meaning IMSS response width; legal values are 32 or 64.
REQ-003 SHALL have parameter PC_W, default 32, meaning PC width.
REQ-004 SHALL have port clk  input  1  sole clock; all state updates on the rising edge.
REQ-005 SHALL have port rst_n  input  1  reset, asynchronous and active-low.
REQ-006 SHALL have port f1_to_f2_valid  input  1  F1 has issued an IMSS request for f1_to_f2_pc.
REQ-007 SHALL have port f1_to_f2_pc  input  PC_W  PC of the F1 request.
REQ-008 SHALL have port f2_ready  output  1  F2 can accept an F1 request this cycle.
REQ-009 SHALL have port f2_flush  input  1  discard all queued and in-flight fetches.
REQ-010 SHALL have port f2_stall  input  1  decode cannot accept output this cycle.
REQ-011 SHALL have port imss_rsp_valid  input  1  IMSS returns one response, in request order.
REQ-012 SHALL have port imss_rsp_data  input  FETCH_W  response data.
REQ-013 SHALL have port f2_to_d_valid  output  1  instruction presented to decode.
REQ-014 SHALL have port f2_to_d_pc  output  PC_W  PC of the presented instruction.
REQ-015 SHALL have port f2_to_d_instr  output  32  presented instruction.
REQ-016 SHALL have port f2_occupancy  output  $clog2(DEPTH+1)  number of allocated entries, filled or unfilled.

Function
REQ-017 SHALL hold a circular queue of DEPTH entries, each holding {pc, instr, filled}, with three pointers: alloc (tail), fill, and head.
REQ-018 SHALL accept an F1 request when f1_to_f2_valid & f2_ready & !f2_flush: write pc at alloc with filled=0, advance alloc, and wrap modulo DEPTH.
REQ-019 SHALL drive f2_ready = (f2_occupancy + drop_cnt) < DEPTH, a combinational function of state only, independent of f2_stall.
REQ-020 SHALL handle each imss_rsp_valid as follows: if drop_cnt > 0, decrement drop_cnt and write nothing; otherwise write instr at fill, set filled=1, and advance fill.
REQ-021 SHALL, for FETCH_W=64, store imss_rsp_data[63:32] when the entry pc[2]=1 and [31:0] otherwise; for FETCH_W=32, store the data as-is.
REQ-022 SHALL drive f2_to_d_valid = head entry allocated & filled & !f2_flush.
REQ-023 SHALL drive f2_to_d_pc and f2_to_d_instr from the head entry; these are don't-care when f2_to_d_valid=0.
REQ-024 SHALL pop the head when f2_to_d_valid & !f2_stall, advancing head with wrap.
REQ-025 SHALL give an IMSS response accepted in cycle N an earliest f2_to_d_valid in cycle N+1, with no combinational response-to-decode bypass.
REQ-026 SHALL support alloc, fill, and pop of different entries in the same cycle; f2_occupancy changes by (+alloc -pop).
REQ-027 SHALL, on f2_flush, set drop_cnt_next = drop_cnt + unfilled_allocated - imss_rsp_valid, then empty the queue so that occupancy becomes 0 and alloc=fill=head.
REQ-028 SHALL, on f2_flush, pop nothing and allocate nothing that cycle, even if f1_to_f2_valid=1.
REQ-029 SHALL never let drop_cnt underflow; it never exceeds DEPTH.
REQ-030 SHALL allow new requests to be accepted while drop_cnt > 0; their responses arrive after the dropped ones and fill normally.
REQ-031 SHALL treat imss_rsp_valid with no allocated-unfilled entry and drop_cnt=0 as a protocol violation, flagged by an assertion under SIMULATION.

Reset
REQ-032 SHALL, while rst_n=0, asynchronously clear all pointers, drop_cnt, and filled bits, giving f2_to_d_valid=0, f2_occupancy=0, and f2_ready=1.
REQ-033 SHALL leave the entry pc and instr storage unreset.
REQ-034 SHALL, on reset mid-operation, discard all in-flight state; the surrounding core resets the IMSS concurrently.

Verification
REQ-035 SHALL verify single fetch: request pc=0x100 in cycle 0, response 0x00000013 in cycle 2 -> f2_to_d_valid=1 in cycle 3 with pc=0x100, instr=0x00000013, and occupancy 1 -> 0 after the pop.
REQ-036 SHALL verify full queue: with DEPTH=4, f2_stall=1, and 4 requests all answered -> f2_ready=0 and occupancy=4; releasing the stall drains 4 instructions in order, one per cycle.
REQ-037 SHALL verify flush with in-flight responses: 3 requests allocated, 1 filled, then f2_flush -> drop_cnt=2; the next 2 responses are discarded and a new request at pc=0x200 yields its own response.
REQ-038 SHALL verify simultaneous flush and response: 2 unfilled entries, with f2_flush and imss_rsp_valid in the same cycle -> drop_cnt=1 and f2_to_d_valid=0 that cycle.
REQ-039 SHALL verify 64-bit select: with FETCH_W=64, pc=0x104 and rsp=0xAAAAAAAA_BBBBBBBB -> instr=0xAAAAAAAA; with pc=0x100 -> instr=0xBBBBBBBB.
REQ-040 SHALL verify pointer wrap: 10 back-to-back fetches with DEPTH=4 and f2_stall=0 -> all 10 are delivered in order with no loss.
